// File: rtl/endstop_emulator_pkg.sv
// -----------------------------------------------------------------------------
// endstop_emulator_pkg
// Shared types and constants for the virtual endstop source and its position
// compare helper.
//   state_e        : burst FSM states (IDLE, BOUNCE, LOCKOUT)
//   SEL_*          : position-source select codes for mux_select
//   DEF_CNT_W      : default width of the bounce period timer
//   DEF_BURST_W    : default width of the burst length / toggle counters
// -----------------------------------------------------------------------------
package endstop_emulator_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BOUNCE  = 2'd1,
    LOCKOUT = 2'd2
  } state_e;

  localparam logic [1:0] SEL_ZERO = 2'd0;
  localparam logic [1:0] SEL_X    = 2'd1;
  localparam logic [1:0] SEL_Y    = 2'd2;
  localparam logic [1:0] SEL_Z    = 2'd3;

  localparam int DEF_CNT_W   = 16;
  localparam int DEF_BURST_W = 8;

endpackage

// File: rtl/endstop_emulator_pos_trip_compare.sv
// -----------------------------------------------------------------------------
// pos_trip_compare
// Selects an axis position and compares it (signed) against a trip point,
// producing the line level the endstop should settle to. Purely combinational,
// so it can be reused by the endstop input path for soft limits.
//   x, y, z     in  32  signed axis positions
//   mux_select  in  2   0 = constant 0, 1 = x, 2 = y, 3 = z
//   trip        in  32  signed trip point
//   direction   in  1   1: triggered when pos >= trip, 0: when pos <= trip
//   polarity    in  1   line level meaning "triggered"
//   target      out 1   polarity when triggered, ~polarity otherwise
// -----------------------------------------------------------------------------
module pos_trip_compare
  import endstop_emulator_pkg::*;
(
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic [31:0] z,
  input  logic [1:0]  mux_select,
  input  logic [31:0] trip,
  input  logic        direction,
  input  logic        polarity,
  output logic        target
);

  logic [31:0] pos_s;
  logic        triggered_s;

  // Position source select.
  always_comb begin
    pos_s = 32'd0;
    case (mux_select)
      SEL_ZERO: pos_s = 32'd0;
      SEL_X:    pos_s = x;
      SEL_Y:    pos_s = y;
      SEL_Z:    pos_s = z;
      default:  pos_s = 32'd0;
    endcase
  end

  // Signed trip compare; equality counts as triggered in both directions.
  always_comb begin
    triggered_s = 1'b0;
    if (direction) begin
      triggered_s = ($signed(pos_s) >= $signed(trip));
    end else begin
      triggered_s = ($signed(pos_s) <= $signed(trip));
    end
    target = triggered_s ? polarity : ~polarity;
  end

endmodule

// File: rtl/endstop_emulator.sv
// -----------------------------------------------------------------------------
// endstop_emulator
// Virtual endstop source. Drives sig_out to the level selected by the position
// compare, adding a deterministic bounce burst (2N+1 toggles, each level held
// P cycles) followed by a P-cycle lockout on every level change.
//   clk, reset     in   single clock, synchronous active-high reset
//   x, y, z        in   signed axis positions
//   mux_select     in   position source select
//   enable         in   gates entry into a new burst only
//   trip           in   signed trip point
//   direction      in   compare direction
//   polarity       in   triggered line level
//   bounce_pairs   in   N, extra toggle pairs per transition
//   bounce_period  in   P, cycles per intermediate level (0 behaves as 1)
//   sig_out        out  emulated raw endstop line (registered)
//   busy           out  high while in BOUNCE or LOCKOUT
//   toggles        out  toggles emitted in the current or last burst
//   transitions    out  completed transitions since reset (wrapping)
// -----------------------------------------------------------------------------
module endstop_emulator
  import endstop_emulator_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int BURST_W = DEF_BURST_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        x,
  input  logic [31:0]        y,
  input  logic [31:0]        z,
  input  logic [1:0]         mux_select,
  input  logic               enable,
  input  logic [31:0]        trip,
  input  logic               direction,
  input  logic               polarity,
  input  logic [BURST_W-1:0] bounce_pairs,
  input  logic [CNT_W-1:0]   bounce_period,
  output logic               sig_out,
  output logic               busy,
  output logic [BURST_W-1:0] toggles,
  output logic [31:0]        transitions
);

  state_e             state_q,       state_d;
  logic               sig_q,         sig_d;
  logic               busy_q,        busy_d;
  logic [BURST_W-1:0] toggles_q,     toggles_d;
  logic [BURST_W:0]   remaining_q,   remaining_d;
  logic [CNT_W-1:0]   timer_q,       timer_d;
  logic [CNT_W-1:0]   reload_q,      reload_d;
  logic [31:0]        transitions_q, transitions_d;

  logic               target_s;
  logic [CNT_W-1:0]   reload_s;

  pos_trip_compare u_cmp (
    .x          (x),
    .y          (y),
    .z          (z),
    .mux_select (mux_select),
    .trip       (trip),
    .direction  (direction),
    .polarity   (polarity),
    .target     (target_s)
  );

  // Timer reload value P-1, with P = 0 behaving like P = 1.
  always_comb begin
    if (bounce_period == {CNT_W{1'b0}}) begin
      reload_s = {CNT_W{1'b0}};
    end else begin
      reload_s = bounce_period - CNT_W'(1);
    end
  end

  // Burst FSM next-state and counter logic. N and P are only looked at on the
  // IDLE exit edge; afterwards the latched reload and remaining count rule.
  always_comb begin
    state_d       = state_q;
    sig_d         = sig_q;
    toggles_d     = toggles_q;
    remaining_d   = remaining_q;
    timer_d       = timer_q;
    reload_d      = reload_q;
    transitions_d = transitions_q;

    case (state_q)
      IDLE: begin
        if (enable && (target_s != sig_q)) begin
          sig_d       = ~sig_q;
          toggles_d   = BURST_W'(1);
          remaining_d = {bounce_pairs, 1'b0};
          timer_d     = reload_s;
          reload_d    = reload_s;
          if (bounce_pairs == {BURST_W{1'b0}}) begin
            state_d = LOCKOUT;
          end else begin
            state_d = BOUNCE;
          end
        end else begin
          state_d = IDLE;
        end
      end

      BOUNCE: begin
        if (timer_q != {CNT_W{1'b0}}) begin
          timer_d = timer_q - CNT_W'(1);
        end else if (remaining_q != {(BURST_W+1){1'b0}}) begin
          sig_d       = ~sig_q;
          toggles_d   = toggles_q + BURST_W'(1);
          remaining_d = remaining_q - (BURST_W+1)'(1);
          timer_d     = reload_q;
          // Last toggle of the burst lands on the latched target level.
          if (remaining_q == (BURST_W+1)'(1)) begin
            state_d = LOCKOUT;
          end else begin
            state_d = BOUNCE;
          end
        end else begin
          // Not reachable in normal operation; recover into the lockout.
          timer_d = reload_q;
          state_d = LOCKOUT;
        end
      end

      LOCKOUT: begin
        if (timer_q != {CNT_W{1'b0}}) begin
          timer_d = timer_q - CNT_W'(1);
        end else begin
          transitions_d = transitions_q + 32'd1;
          state_d       = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      sig_q         <= ~polarity;
      busy_q        <= 1'b0;
      toggles_q     <= {BURST_W{1'b0}};
      remaining_q   <= {(BURST_W+1){1'b0}};
      timer_q       <= {CNT_W{1'b0}};
      reload_q      <= {CNT_W{1'b0}};
      transitions_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      sig_q         <= sig_d;
      busy_q        <= busy_d;
      toggles_q     <= toggles_d;
      remaining_q   <= remaining_d;
      timer_q       <= timer_d;
      reload_q      <= reload_d;
      transitions_q <= transitions_d;
    end
  end

  assign sig_out     = sig_q;
  assign busy        = busy_q;
  assign toggles     = toggles_q;
  assign transitions = transitions_q;

endmodule
